// File: rtl/sap_controller.sv
// sap_controller: T-state sequencer and control-word decoder for the 4-bit SAP datapath.
// One-hot ring T1..T6 plus HALT; one control word per clock, gated off while reset or run is low.
module sap_controller #(
  parameter logic [3:0] OPC_LDA = 4'h0,
  parameter logic [3:0] OPC_ADD = 4'h1,
  parameter logic [3:0] OPC_SUB = 4'h2,
  parameter logic [3:0] OPC_JMP = 4'h3,
  parameter logic [3:0] OPC_JZ  = 4'h4,
  parameter logic [3:0] OPC_JC  = 4'h5,
  parameter logic [3:0] OPC_OUT = 4'hE,
  parameter logic [3:0] OPC_HLT = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       jump,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halted,
  output logic [5:0] t_state
);

  typedef enum logic [6:0] {
    ST_T1   = 7'b000_0001,
    ST_T2   = 7'b000_0010,
    ST_T3   = 7'b000_0100,
    ST_T4   = 7'b000_1000,
    ST_T5   = 7'b001_0000,
    ST_T6   = 7'b010_0000,
    ST_HALT = 7'b100_0000
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic jump;
    logic mar_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_in;
  } ctrl_t;

  state_t     state;
  state_t     state_next;
  state_t     step;
  logic       legal;
  ctrl_t      raw;
  ctrl_t      ctrl;
  logic [6:0] state_bits;

  // State register: reset forces T1 from any state, otherwise take the decoded next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_T1;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control-word decode; controls are zeroed unless reset is released and run is high.
  always_comb begin
    raw        = '0;
    step       = ST_T1;
    legal      = 1'b1;
    state_next = ST_T1;
    ctrl       = '0;
    case (state)
      ST_T1: begin
        raw.pc_out = 1'b1;
        raw.mar_in = 1'b1;
        step       = ST_T2;
      end
      ST_T2: begin
        raw.pc_inc = 1'b1;
        step       = ST_T3;
      end
      ST_T3: begin
        raw.ram_out = 1'b1;
        raw.ir_in   = 1'b1;
        step        = ST_T4;
      end
      ST_T4: begin
        case (opcode)
          OPC_LDA, OPC_ADD, OPC_SUB: begin
            raw.ir_out = 1'b1;
            raw.mar_in = 1'b1;
            step       = ST_T5;
          end
          OPC_OUT: begin
            raw.a_out  = 1'b1;
            raw.out_in = 1'b1;
            step       = ST_T1;
          end
          OPC_JMP: begin
            raw.ir_out = 1'b1;
            raw.jump   = 1'b1;
            step       = ST_T1;
          end
          OPC_JZ: begin
            raw.ir_out = flag_z;
            raw.jump   = flag_z;
            step       = ST_T1;
          end
          OPC_JC: begin
            raw.ir_out = flag_c;
            raw.jump   = flag_c;
            step       = ST_T1;
          end
          OPC_HLT: begin
            step = ST_HALT;
          end
          default: begin
            step = ST_T1;
          end
        endcase
      end
      ST_T5: begin
        case (opcode)
          OPC_LDA: begin
            raw.ram_out = 1'b1;
            raw.a_in    = 1'b1;
            step        = ST_T1;
          end
          OPC_ADD, OPC_SUB: begin
            raw.ram_out = 1'b1;
            raw.b_in    = 1'b1;
            step        = ST_T6;
          end
          default: begin
            // Opcode changed under a memory execute: abandon quietly.
            step = ST_T1;
          end
        endcase
      end
      ST_T6: begin
        raw.alu_out  = 1'b1;
        raw.a_in     = 1'b1;
        raw.flags_in = 1'b1;
        raw.alu_sub  = (opcode == OPC_SUB);
        step         = ST_T1;
      end
      ST_HALT: begin
        step = ST_HALT;
      end
      default: begin
        // Corrupted encoding: recover to T1 even when run is low.
        legal = 1'b0;
        step  = ST_T1;
      end
    endcase
    state_next = (run || !legal) ? step : state;
    ctrl       = (reset && run) ? raw : ctrl_t'(14'h0000);
  end

  assign state_bits = state;
  assign t_state    = state_bits[5:0];
  assign halted     = state_bits[6];

  assign pc_inc   = ctrl.pc_inc;
  assign pc_out   = ctrl.pc_out;
  assign jump     = ctrl.jump;
  assign mar_in   = ctrl.mar_in;
  assign ram_out  = ctrl.ram_out;
  assign ir_in    = ctrl.ir_in;
  assign ir_out   = ctrl.ir_out;
  assign a_in     = ctrl.a_in;
  assign a_out    = ctrl.a_out;
  assign b_in     = ctrl.b_in;
  assign alu_out  = ctrl.alu_out;
  assign alu_sub  = ctrl.alu_sub;
  assign flags_in = ctrl.flags_in;
  assign out_in   = ctrl.out_in;

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed checks of the SAP sequencer plus a randomized invariant sweep.
module tb_sap_controller;

  logic       clock;
  logic       reset;
  logic       run;
  logic [3:0] opcode;
  logic       flag_z;
  logic       flag_c;
  logic       pc_inc, pc_out, jump, mar_in, ram_out, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
  logic       halted;
  logic [5:0] t_state;
  logic [13:0] cw;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int pulse_cnt = 0;

  localparam logic [13:0] C_NONE     = 14'h0000;
  localparam logic [13:0] C_PC_INC   = 14'h2000;
  localparam logic [13:0] C_PC_OUT   = 14'h1000;
  localparam logic [13:0] C_JUMP     = 14'h0800;
  localparam logic [13:0] C_MAR_IN   = 14'h0400;
  localparam logic [13:0] C_RAM_OUT  = 14'h0200;
  localparam logic [13:0] C_IR_IN    = 14'h0100;
  localparam logic [13:0] C_IR_OUT   = 14'h0080;
  localparam logic [13:0] C_A_IN     = 14'h0040;
  localparam logic [13:0] C_A_OUT    = 14'h0020;
  localparam logic [13:0] C_B_IN     = 14'h0010;
  localparam logic [13:0] C_ALU_OUT  = 14'h0008;
  localparam logic [13:0] C_ALU_SUB  = 14'h0004;
  localparam logic [13:0] C_FLAGS_IN = 14'h0002;
  localparam logic [13:0] C_OUT_IN   = 14'h0001;

  localparam logic [5:0] T1 = 6'h01;
  localparam logic [5:0] T2 = 6'h02;
  localparam logic [5:0] T3 = 6'h04;
  localparam logic [5:0] T4 = 6'h08;
  localparam logic [5:0] T5 = 6'h10;
  localparam logic [5:0] T6 = 6'h20;
  localparam logic [5:0] TH = 6'h00;

  sap_controller dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .flag_z(flag_z), .flag_c(flag_c),
    .pc_inc(pc_inc), .pc_out(pc_out), .jump(jump), .mar_in(mar_in),
    .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in),
    .alu_out(alu_out), .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in),
    .halted(halted), .t_state(t_state)
  );

  assign cw = {pc_inc, pc_out, jump, mar_in, ram_out, ir_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Settle combinational outputs, then compare t_state, control word and halted.
  task automatic at(input string tag, input logic [5:0] t, input logic [13:0] c, input logic h);
    #1;
    chk({tag, "/t"}, 32'(t_state), 32'(t));
    chk({tag, "/cw"}, 32'(cw), 32'(c));
    chk({tag, "/h"}, 32'(halted), 32'(h));
  endtask

  task automatic fetch(input string tag);
    at({tag, "/T1"}, T1, C_PC_OUT | C_MAR_IN, 1'b0); cyc();
    at({tag, "/T2"}, T2, C_PC_INC, 1'b0);            cyc();
    at({tag, "/T3"}, T3, C_RAM_OUT | C_IR_IN, 1'b0); cyc();
  endtask

  initial begin
    int drv;
    reset = 1'b0; run = 1'b0; opcode = 4'h0; flag_z = 1'b0; flag_c = 1'b0;
    cyc(); cyc();
    at("por", T1, C_NONE, 1'b0);

    // Reset held two clocks in the middle of an ADD at T5.
    reset = 1'b1; run = 1'b1; opcode = 4'h1;
    fetch("pre");
    at("pre/T4", T4, C_IR_OUT | C_MAR_IN, 1'b0); cyc();
    at("pre/T5", T5, C_RAM_OUT | C_B_IN, 1'b0);
    reset = 1'b0;
    at("rst_lo", T5, C_NONE, 1'b0);
    cyc(); cyc();
    at("rst_held", T1, C_NONE, 1'b0);
    reset = 1'b1;

    // ADD: full six-cycle sequence, alu_sub low.
    fetch("add");
    at("add/T4", T4, C_IR_OUT | C_MAR_IN, 1'b0); cyc();
    at("add/T5", T5, C_RAM_OUT | C_B_IN, 1'b0);  cyc();
    at("add/T6", T6, C_ALU_OUT | C_A_IN | C_FLAGS_IN, 1'b0); cyc();

    // SUB: same as ADD with alu_sub in T6.
    opcode = 4'h2;
    fetch("sub");
    at("sub/T4", T4, C_IR_OUT | C_MAR_IN, 1'b0); cyc();
    at("sub/T5", T5, C_RAM_OUT | C_B_IN, 1'b0);  cyc();
    at("sub/T6", T6, C_ALU_OUT | C_A_IN | C_FLAGS_IN | C_ALU_SUB, 1'b0); cyc();

    // LDA: five cycles.
    opcode = 4'h0;
    fetch("lda");
    at("lda/T4", T4, C_IR_OUT | C_MAR_IN, 1'b0); cyc();
    at("lda/T5", T5, C_RAM_OUT | C_A_IN, 1'b0);  cyc();

    // OUT, JMP, NOP: four cycles each.
    opcode = 4'hE;
    fetch("out");
    at("out/T4", T4, C_A_OUT | C_OUT_IN, 1'b0); cyc();
    opcode = 4'h3;
    fetch("jmp");
    at("jmp/T4", T4, C_IR_OUT | C_JUMP, 1'b0); cyc();
    opcode = 4'h7;
    fetch("nop");
    at("nop/T4", T4, C_NONE, 1'b0); cyc();

    // JZ with flag_z low then high; JC with flag_c high then low.
    opcode = 4'h4; flag_z = 1'b0; flag_c = 1'b1;
    fetch("jz0");
    at("jz0/T4", T4, C_NONE, 1'b0); cyc();
    flag_z = 1'b1; flag_c = 1'b0;
    fetch("jz1");
    at("jz1/T4", T4, C_IR_OUT | C_JUMP, 1'b0); cyc();
    opcode = 4'h5; flag_z = 1'b1; flag_c = 1'b1;
    fetch("jc1");
    at("jc1/T4", T4, C_IR_OUT | C_JUMP, 1'b0); cyc();
    flag_c = 1'b0;
    fetch("jc0");
    at("jc0/T4", T4, C_NONE, 1'b0); cyc();
    at("jc0/back", T1, C_PC_OUT | C_MAR_IN, 1'b0);

    // run toggled 1,0,0,1 while at T2: frozen two cycles, one pc_inc pulse.
    opcode = 4'h7; flag_z = 1'b0;
    cyc();
    run = 1'b0;
    at("frz0", T2, C_NONE, 1'b0); pulse_cnt += int'(pc_inc); cyc();
    at("frz1", T2, C_NONE, 1'b0); pulse_cnt += int'(pc_inc); cyc();
    run = 1'b1;
    at("frz_rel", T2, C_PC_INC, 1'b0); pulse_cnt += int'(pc_inc); cyc();
    at("frz_T3", T3, C_RAM_OUT | C_IR_IN, 1'b0); pulse_cnt += int'(pc_inc);
    chk("pc_inc_pulses", 32'(pulse_cnt), 32'd1);
    cyc();
    at("frz_T4", T4, C_NONE, 1'b0); cyc();

    // HLT: halted with zero controls for 20 cycles, run ignored; reset recovers.
    opcode = 4'hF;
    fetch("hlt");
    at("hlt/T4", T4, C_NONE, 1'b0); cyc();
    for (int i = 0; i < 20; i++) begin
      run = (i % 7 == 3) ? 1'b0 : 1'b1;
      at("halt", TH, C_NONE, 1'b1);
      cyc();
    end
    run = 1'b1;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    at("hlt_rec", T1, C_PC_OUT | C_MAR_IN, 1'b0);

    // Randomized sweep: bus-driver exclusivity and jump/pc_inc exclusion every cycle.
    for (int i = 0; i < 10000; i++) begin
      if (t_state == T1) opcode = 4'($urandom_range(0, 15));
      flag_z = 1'($urandom_range(0, 1));
      flag_c = 1'($urandom_range(0, 1));
      run    = ($urandom_range(0, 7) != 0);
      reset  = ($urandom_range(0, 63) != 0);
      #1;
      drv = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
      chk("bus_1hot", 32'(drv <= 1), 32'd1);
      chk("jmp_inc_excl", 32'(jump & pc_inc), 32'd0);
      if (halted) chk("halt_quiet", 32'({t_state, cw}), 32'd0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
